// File: rtl/cpu6_trap_ctrl_if.sv
// Trap-controller bus: interrupt/CSR inputs, drain handshake and fetch redirect.
// The ecallE signal exists only when CPU6_TRAP_ECALL_EN is defined.
interface cpu6_trap_ctrl_if;
  logic        tmr_irq_r;
  logic        ext_irq_r;
  logic        csr_mtie_r;
  logic        csr_meie_r;
  logic        csr_mstatus_mie_r;
  logic        mretE;
  logic        pcsrcE;
`ifdef CPU6_TRAP_ECALL_EN
  logic        ecallE;
`endif
  logic [31:0] next_pcF;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        empty_pipeline_ackW;
  logic        empty_pipeline_reqE;
  logic        stallF;
  logic [31:0] excp_mepc;
  logic        excp_mepc_ena;
  logic [31:0] excp_mcause;
  logic        mret_ena;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        err_timeout;

  // The trap controller side.
  modport master (
`ifdef CPU6_TRAP_ECALL_EN
    input  ecallE,
`endif
    input  tmr_irq_r, ext_irq_r, csr_mtie_r, csr_meie_r, csr_mstatus_mie_r,
    input  mretE, pcsrcE, next_pcF, csr_mtvec, csr_mepc, empty_pipeline_ackW,
    output empty_pipeline_reqE, stallF, excp_mepc, excp_mepc_ena, excp_mcause,
    output mret_ena, redirect_valid, redirect_pc, busy, err_timeout
  );

  // The pipeline / CSR-file side.
  modport slave (
`ifdef CPU6_TRAP_ECALL_EN
    output ecallE,
`endif
    output tmr_irq_r, ext_irq_r, csr_mtie_r, csr_meie_r, csr_mstatus_mie_r,
    output mretE, pcsrcE, next_pcF, csr_mtvec, csr_mepc, empty_pipeline_ackW,
    input  empty_pipeline_reqE, stallF, excp_mepc, excp_mepc_ena, excp_mcause,
    input  mret_ena, redirect_valid, redirect_pc, busy, err_timeout
  );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// Machine-mode interrupt entry / MRET sequencer: drain, save mepc/mcause, redirect.
// Define CPU6_TRAP_ECALL_EN to add the ecallE synchronous-exception entry.
module cpu6_trap_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic             clk,
  input logic             reset,
  cpu6_trap_ctrl_if.master trap
);

  typedef enum logic [2:0] {
    IDLE, IRQ_DRAIN, IRQ_SAVE, IRQ_JUMP, RET_DRAIN, RET_JUMP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [31:0]      resumePc, resumePcNext;
  logic [31:0]      cause, causeNext;
  logic             errTimeout, errNext;
  logic             irqExt, irqTmr;

  assign irqExt = trap.ext_irq_r & trap.csr_meie_r & trap.csr_mstatus_mie_r;
  assign irqTmr = trap.tmr_irq_r & trap.csr_mtie_r & trap.csr_mstatus_mie_r;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    resumePcNext = resumePc;
    causeNext    = cause;
    errNext      = errTimeout;
    unique case (state)
      IDLE: begin
        cntNext = '0;
        if (trap.mretE) begin
          stateNext = RET_DRAIN;
`ifdef CPU6_TRAP_ECALL_EN
        end else if (trap.ecallE) begin
          stateNext    = IRQ_DRAIN;
          resumePcNext = trap.next_pcF - 32'd4;
          causeNext    = 32'h0000_000B;
`endif
        end else if ((irqExt | irqTmr) & ~trap.pcsrcE) begin
          stateNext    = IRQ_DRAIN;
          resumePcNext = trap.next_pcF;
          causeNext    = irqExt ? 32'h8000_000B : 32'h8000_0007;
        end
      end
      IRQ_DRAIN, RET_DRAIN: begin
        // A missing ack is flagged, then the sequence completes as if acked.
        if (trap.empty_pipeline_ackW || cnt == CNT_LAST) begin
          stateNext = (state == IRQ_DRAIN) ? IRQ_SAVE : RET_JUMP;
          cntNext   = '0;
          if (!trap.empty_pipeline_ackW) errNext = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      IRQ_SAVE: stateNext = IRQ_JUMP;
      IRQ_JUMP: stateNext = IDLE;
      RET_JUMP: stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resumePc   <= '0;
      cause      <= '0;
      errTimeout <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      resumePc   <= resumePcNext;
      cause      <= causeNext;
      errTimeout <= errNext;
    end
  end

  // Outputs decode the registered state only; the CSR buses are passed through when selected.
  always_comb begin
    trap.empty_pipeline_reqE = 1'b0;
    trap.excp_mepc_ena       = 1'b0;
    trap.excp_mepc           = '0;
    trap.excp_mcause         = '0;
    trap.mret_ena            = 1'b0;
    trap.redirect_valid      = 1'b0;
    trap.redirect_pc         = '0;
    unique case (state)
      IRQ_DRAIN, RET_DRAIN: trap.empty_pipeline_reqE = 1'b1;
      IRQ_SAVE: begin
        trap.excp_mepc_ena = 1'b1;
        trap.excp_mepc     = resumePc;
        trap.excp_mcause   = cause;
      end
      IRQ_JUMP: begin
        trap.redirect_valid = 1'b1;
        trap.redirect_pc    = trap.csr_mtvec & ~32'h3;
      end
      RET_JUMP: begin
        trap.mret_ena       = 1'b1;
        trap.redirect_valid = 1'b1;
        trap.redirect_pc    = trap.csr_mepc;
      end
      default: ;
    endcase
  end

  assign trap.busy        = (state != IDLE);
  assign trap.stallF      = (state != IDLE);
  assign trap.err_timeout = errTimeout;

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Directed bench for cpu6_trap_ctrl: stimulus pushes expected strobe events,
// a negedge monitor pops and compares them whenever the DUT raises a strobe.
module tb_cpu6_trap_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu6_trap_ctrl_if bus ();

  cpu6_trap_ctrl #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .trap (bus)
  );

  typedef enum logic [1:0] {EV_SAVE, EV_JUMP, EV_RET} ev_t;
  typedef struct {
    ev_t         kind;
    logic [31:0] pc;
    logic [31:0] cause;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input ev_t kind, input logic [31:0] pc, input logic [31:0] cause);
    exp_t e;
    e.kind  = kind;
    e.pc    = pc;
    e.cause = cause;
    sbq.push_back(e);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.excp_mepc_ena || bus.redirect_valid || bus.mret_ena) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe",
              {29'd0, bus.excp_mepc_ena, bus.redirect_valid, bus.mret_ena}, 32'd0);
      end else begin
        exp_t e;
        ev_t  got;
        e   = sbq.pop_front();
        got = bus.excp_mepc_ena ? EV_SAVE : (bus.mret_ena ? EV_RET : EV_JUMP);
        check("event_kind", 32'(got), 32'(e.kind));
        if (e.kind == EV_SAVE) begin
          check("excp_mepc", bus.excp_mepc, e.pc);
          check("excp_mcause", bus.excp_mcause, e.cause);
          check("save_no_redirect", 32'(bus.redirect_valid), 32'd0);
        end else begin
          check("redirect_valid", 32'(bus.redirect_valid), 32'd1);
          check("redirect_pc", bus.redirect_pc, e.pc);
          check("mret_ena", 32'(bus.mret_ena), 32'(e.kind == EV_RET));
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.tmr_irq_r           = 1'b0;
    bus.ext_irq_r           = 1'b0;
    bus.csr_mtie_r          = 1'b0;
    bus.csr_meie_r          = 1'b0;
    bus.csr_mstatus_mie_r   = 1'b0;
    bus.mretE               = 1'b0;
    bus.pcsrcE              = 1'b0;
`ifdef CPU6_TRAP_ECALL_EN
    bus.ecallE              = 1'b0;
`endif
    bus.next_pcF            = '0;
    bus.csr_mtvec           = '0;
    bus.csr_mepc            = '0;
    bus.empty_pipeline_ackW = 1'b0;
  endtask

  // Starts in the first drain cycle; acks on drain cycle ackAt.
  task automatic drain(input string tag, input int ackAt);
    for (int i = 1; i <= ackAt; i++) begin
      bus.empty_pipeline_ackW = (i == ackAt);
      @(negedge clk);
      check({tag, "_req"}, 32'(bus.empty_pipeline_reqE), 32'd1);
      check({tag, "_stall_drain"}, 32'(bus.stallF), 32'd1);
      tick();
    end
    bus.empty_pipeline_ackW = 1'b0;
  endtask

  // Caller sets the trigger inputs; this accepts, drains and checks the tail of the sequence.
  task automatic run_seq(input string tag, input logic isRet, input logic [31:0] nextPc,
                         input logic [31:0] expPc, input logic [31:0] expCause, input int ackAt);
    bus.next_pcF = nextPc;
    @(negedge clk);
    check({tag, "_idle_before"}, 32'(bus.busy), 32'd0);
    if (isRet) begin
      expect_ev(EV_RET, bus.csr_mepc, 32'd0);
    end else begin
      expect_ev(EV_SAVE, expPc, expCause);
      expect_ev(EV_JUMP, {bus.csr_mtvec[31:2], 2'b00}, 32'd0);
    end
    tick();
    bus.tmr_irq_r = 1'b0;
    bus.ext_irq_r = 1'b0;
    bus.mretE     = 1'b0;
`ifdef CPU6_TRAP_ECALL_EN
    bus.ecallE    = 1'b0;
`endif
    bus.next_pcF  = 32'hDEAD_0000;
    drain(tag, ackAt);
    @(negedge clk);
    check({tag, "_stall_post1"}, 32'(bus.stallF), 32'd1);
    if (!isRet) begin
      tick();
      @(negedge clk);
      check({tag, "_stall_post2"}, 32'(bus.stallF), 32'd1);
    end
    tick();
    @(negedge clk);
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_stall_after"}, 32'(bus.stallF), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_inputs();
    reset = 1'b0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.stallF), 32'd0);
    check("rst_req", 32'(bus.empty_pipeline_reqE), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_mepc", bus.excp_mepc, 32'd0);
    check("rst_mcause", bus.excp_mcause, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Timer interrupt, ack on the third drain cycle.
    bus.csr_mtvec = 32'h0000_0080;
    bus.tmr_irq_r = 1'b1; bus.csr_mtie_r = 1'b1; bus.csr_mstatus_mie_r = 1'b1;
    run_seq("tmr", 1'b0, 32'h100, 32'h100, 32'h8000_0007, 3);

    // Ext and timer together: external wins; mtvec low bits are masked.
    bus.csr_mtvec = 32'h0000_0083;
    bus.csr_meie_r = 1'b1; bus.ext_irq_r = 1'b1; bus.tmr_irq_r = 1'b1;
    run_seq("ext_tmr", 1'b0, 32'h140, 32'h140, 32'h8000_000B, 2);

    // Global MIE off: nothing happens.
    bus.csr_mstatus_mie_r = 1'b0; bus.ext_irq_r = 1'b1; bus.tmr_irq_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mie_off_busy", 32'(bus.busy), 32'd0);
      check("mie_off_req", 32'(bus.empty_pipeline_reqE), 32'd0);
      tick();
    end
    bus.ext_irq_r = 1'b0; bus.tmr_irq_r = 1'b0; bus.csr_mstatus_mie_r = 1'b1;

    // Ack while idle is ignored.
    bus.empty_pipeline_ackW = 1'b1;
    tick();
    bus.empty_pipeline_ackW = 1'b0;
    @(negedge clk);
    check("idle_ack_busy", 32'(bus.busy), 32'd0);
    tick();

    // Branch in EX defers the interrupt.
    bus.ext_irq_r = 1'b1; bus.pcsrcE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("defer_req", 32'(bus.empty_pipeline_reqE), 32'd0);
      check("defer_busy", 32'(bus.busy), 32'd0);
    end
    tick();
    bus.pcsrcE = 1'b0;
    run_seq("deferred", 1'b0, 32'h200, 32'h200, 32'h8000_000B, 1);

    // MRET alone, then MRET with a pending timer irq.
    bus.csr_mepc = 32'h104; bus.mretE = 1'b1;
    run_seq("mret", 1'b1, 32'h300, 32'h0, 32'h0, 1);
    bus.csr_mepc = 32'h208; bus.mretE = 1'b1; bus.tmr_irq_r = 1'b1;
    run_seq("mret_tmr", 1'b1, 32'h310, 32'h0, 32'h0, 2);

`ifdef CPU6_TRAP_ECALL_EN
    // ecall outranks a pending irq and saves the ecall address.
    bus.ecallE = 1'b1; bus.tmr_irq_r = 1'b1;
    run_seq("ecall", 1'b0, 32'h404, 32'h400, 32'h0000_000B, 1);
`endif

    // No ack: timeout after 16 drain cycles, sequence still completes.
    bus.csr_mtvec = 32'h0000_0080;
    bus.tmr_irq_r = 1'b1;
    bus.next_pcF  = 32'h500;
    expect_ev(EV_SAVE, 32'h500, 32'h8000_0007);
    expect_ev(EV_JUMP, 32'h80, 32'd0);
    tick();
    bus.tmr_irq_r = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.empty_pipeline_reqE && n < 40) begin
      n++;
      if (n == 16) check("timeout_err_late", 32'(bus.err_timeout), 32'd0);
      tick();
      @(negedge clk);
    end
    check("timeout_drain_cycles", 32'(n), 32'd16);
    check("timeout_err_set", 32'(bus.err_timeout), 32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    check("timeout_err_sticky", 32'(bus.err_timeout), 32'd1);
    check("timeout_idle", 32'(bus.busy), 32'd0);
    tick();

    // Reset mid-drain aborts, then a fresh entry with the irq still held.
    bus.tmr_irq_r = 1'b1;
    bus.next_pcF  = 32'h2F0;
    tick();
    drain("pre_rst", 0);
    @(negedge clk);
    check("pre_rst_req", 32'(bus.empty_pipeline_reqE), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_req", 32'(bus.empty_pipeline_reqE), 32'd0);
    check("mid_rst_stall", 32'(bus.stallF), 32'd0);
    check("mid_rst_err", 32'(bus.err_timeout), 32'd0);
    tick();
    reset = 1'b1;
    run_seq("post_rst", 1'b0, 32'h300, 32'h300, 32'h8000_0007, 2);

    repeat (3) tick();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cpu6_trap_ctrl.md
Name: cpu6_trap_ctrl

Overview:
- Sequences machine-mode interrupt entry and MRET return for the cpu6 pipeline.
- Takes pending timer/external interrupts qualified by CSR enables. Drains the pipeline through the empty_pipeline req/ack handshake, writes mepc/mcause, then redirects fetch to mtvec.
- On MRET it drains, pulses mret_ena to the CSR file, and redirects fetch to mepc.
- Sits between fetch/PC logic and the datapath's CSR/empty-pipeline ports.

Parameters:
- ACK_TIMEOUT, 16: max cycles in a drain state waiting for ack before err_timeout is set.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- tmr_irq_r  input  1  timer interrupt pending (registered)
- ext_irq_r  input  1  external interrupt pending (registered)
- csr_mtie_r  input  1  mie.MTIE
- csr_meie_r  input  1  mie.MEIE
- csr_mstatus_mie_r  input  1  mstatus.MIE
- mretE  input  1  MRET decoded in EX
- pcsrcE  input  1  branch/jump in EX
- next_pcF  input  32  address of next instruction fetch would issue
- csr_mtvec  input  32  trap vector
- csr_mepc  input  32  return address
- empty_pipeline_ackW  input  1  drain acknowledge from WB
- empty_pipeline_reqE  output  1  drain request into EX
- stallF  output  1  hold fetch
- excp_mepc  output  32  value to write into mepc
- excp_mepc_ena  output  1  mepc write strobe
- excp_mcause  output  32  cause code
- mret_ena  output  1  MRET strobe to CSR file
- redirect_valid  output  1  one-cycle fetch redirect
- redirect_pc  output  32  redirect target
- busy  output  1  state != IDLE
- err_timeout  output  1  sticky ack-timeout flag

Behaviour:
- Reset (reset==0, async):
  - state = IDLE, counter = 0.
  - All outputs 0, including err_timeout and both 32-bit buses.
- Interrupt qualification:
  - irq_ext = ext_irq_r & csr_meie_r & csr_mstatus_mie_r.
  - irq_tmr = tmr_irq_r & csr_mtie_r & csr_mstatus_mie_r.
  - External has priority over timer.
- States: IDLE, IRQ_DRAIN, IRQ_SAVE, IRQ_JUMP, RET_DRAIN, RET_JUMP.
- IDLE:
  - If mretE: go to RET_DRAIN. MRET wins over a simultaneous irq.
  - Else if (irq_ext | irq_tmr) & ~pcsrcE: go to IRQ_DRAIN. Latch resume_pc = next_pcF and cause = ext ? 0x8000000B : 0x80000007.
  - An irq with pcsrcE=1 is deferred; it is re-evaluated every cycle.
- IRQ_DRAIN / RET_DRAIN:
  - empty_pipeline_reqE=1 and stallF=1; counter increments.
  - On ack: go to IRQ_SAVE / RET_JUMP and clear counter.
  - If counter reaches ACK_TIMEOUT without ack: set err_timeout, then proceed as if acked.
  - An ack arriving while in IDLE is ignored.
- IRQ_SAVE, one cycle:
  - excp_mepc_ena=1, excp_mepc=resume_pc, excp_mcause=cause, stallF=1.
- IRQ_JUMP, one cycle:
  - redirect_valid=1, redirect_pc = {csr_mtvec[31:2],2'b00}, stallF=1; then IDLE.
- RET_JUMP, one cycle:
  - mret_ena=1, redirect_valid=1, redirect_pc = csr_mepc, stallF=1; then IDLE.
  - csr_mepc is sampled in this cycle, before the mret_ena edge takes effect.
- Interrupt state changes after IRQ_DRAIN entry do not abort or alter the sequence. The latched cause is used.
- Latency, irq to redirect: 1 (accept) + drain cycles + 2.
- stallF is high in every non-IDLE state.
- Outputs are registered-state decodes. No combinational path from irq inputs to outputs.
- Reset asserted mid-sequence returns to IDLE immediately with all strobes low; a partial sequence is not resumed.

Optional Feature:
- Macro: CPU6_TRAP_ECALL_EN.
- When defined:
  - Adds input ecallE (1 bit).
  - In IDLE, ecallE has priority over irqs, below mretE.
  - Enters IRQ_DRAIN with cause 0x0000000B and resume_pc = address of the ecall instruction, computed as next_pcF − 4.
- When undefined: no ecallE port and no synchronous-exception path.

Test Plan:
- Timer irq: tmr_irq_r=1, mtie=1, mie=1, next_pcF=0x100, mtvec=0x80, ack 3 cycles later -> excp_mepc_ena pulse with mepc=0x100, mcause=0x80000007; redirect_valid pulse with redirect_pc=0x80; stallF high throughout.
- Simultaneous ext and tmr with meie=1 -> mcause=0x8000000B. With mstatus.mie=0 -> state stays IDLE, no req.
- irq with pcsrcE=1 for 2 cycles -> no req during those cycles. pcsrcE=0 with next_pcF=0x200 -> entry with mepc=0x200.
- mretE with csr_mepc=0x104 and ack after 1 cycle -> single-cycle mret_ena and redirect_valid, redirect_pc=0x104. mretE together with tmr irq -> MRET path taken.
- No ack, ACK_TIMEOUT=16 -> err_timeout set after 16 drain cycles and stays set. Sequence completes with redirect.
- reset=0 asserted during IRQ_DRAIN -> outputs immediately 0, busy=0. After reset=1 with irq held -> fresh entry.
